// File: rtl/reaction_ctrl.sv
// Reaction-time game controller: random wait, stimulus light, ms timing of the
// reaction, and cheat/timeout detection, driving an external BCD ms counter chain.
module reaction_ctrl #(
  parameter int CLK_PER_MS  = 100000,
  parameter int WAIT_MIN_MS = 2000,
  parameter int RAND_BITS   = 11,
  parameter int TIMEOUT_MS  = 1000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        start_btn,
  input  logic        stop_btn,
  input  logic        clear_btn,
  output logic        timer_clr,
  output logic        timer_inc,
  output logic        stim_led,
  output logic [1:0]  disp_sel,
  output logic [13:0] react_ms,
  output logic [2:0]  state
);

  localparam int              PW        = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0]   PRE_TC    = PW'(CLK_PER_MS - 1);
  localparam logic [15:0]     WAIT_MIN  = 16'(WAIT_MIN_MS);
  localparam logic [13:0]     REACT_MAX = '1;
  localparam logic [13:0]     TIMEOUT   = 14'(TIMEOUT_MS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_REACT   = 3'd2,
    S_RESULT  = 3'd3,
    S_TIMEOUT = 3'd4,
    S_CHEAT   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    sync1_q, sync2_q, sync3_q;  // bit order {clear, stop, start}
  logic          start_e, stop_e, clear_e;
  logic [15:0]   lfsr_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   ms_cnt_q, ms_cnt_d, ms_next;
  logic [15:0]   wait_tgt_q, wait_tgt_d;
  logic [13:0]   react_q, react_d, react_inc;
  logic          timed, ms_tick;
  logic          stim_q;
  logic [1:0]    disp_q, disp_d;

  assign start_e   = sync2_q[0] & ~sync3_q[0];
  assign stop_e    = sync2_q[1] & ~sync3_q[1];
  assign clear_e   = sync2_q[2] & ~sync3_q[2];
  assign timed     = (state_q == S_WAIT) || (state_q == S_REACT);
  assign ms_tick   = timed && (presc_q == PRE_TC);
  assign ms_next   = ms_cnt_q + 16'd1;
  assign react_inc = (react_q == REACT_MAX) ? react_q : react_q + 14'd1;

  always_comb begin
    state_d    = state_q;
    ms_cnt_d   = ms_cnt_q;
    wait_tgt_d = wait_tgt_q;
    react_d    = react_q;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_e) begin
          state_d    = S_WAIT;
          wait_tgt_d = WAIT_MIN + 16'(lfsr_q[RAND_BITS-1:0]);
          timer_clr  = 1'b1;
          react_d    = '0;
          ms_cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (clear_e) begin
          state_d = S_IDLE;
        end else if (stop_e) begin
          state_d = S_CHEAT;
        end else if (ms_tick) begin
          ms_cnt_d = ms_next;
          if (ms_next >= wait_tgt_q) begin
            state_d  = S_REACT;
            ms_cnt_d = '0;
          end
        end
      end
      S_REACT: begin
        if (clear_e) begin
          state_d = S_IDLE;
        end else begin
          // A tick coinciding with stop is still counted before freezing.
          if (ms_tick) begin
            timer_inc = 1'b1;
            react_d   = react_inc;
          end
          if (stop_e) begin
            state_d = S_RESULT;
          end else if (ms_tick && (react_inc == TIMEOUT)) begin
            state_d = S_TIMEOUT;
          end
        end
      end
      S_RESULT, S_TIMEOUT, S_CHEAT: begin
        if (clear_e) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Prescaler restarts on every state change so each timed state gets a full first ms.
  always_comb begin
    presc_d = '0;
    if (timed && (state_d == state_q)) presc_d = ms_tick ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    case (state_d)
      S_WAIT:                      disp_d = 2'd1;
      S_REACT, S_RESULT, S_TIMEOUT: disp_d = 2'd2;
      S_CHEAT:                     disp_d = 2'd3;
      default:                     disp_d = 2'd0;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync3_q    <= '0;
      lfsr_q     <= 16'hACE1;
      state_q    <= S_IDLE;
      presc_q    <= '0;
      ms_cnt_q   <= '0;
      wait_tgt_q <= '0;
      react_q    <= '0;
      stim_q     <= 1'b0;
      disp_q     <= 2'd0;
    end else begin
      sync1_q    <= {clear_btn, stop_btn, start_btn};
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      lfsr_q     <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      state_q    <= state_d;
      presc_q    <= presc_d;
      ms_cnt_q   <= ms_cnt_d;
      wait_tgt_q <= wait_tgt_d;
      react_q    <= react_d;
      stim_q     <= (state_d == S_REACT);
      disp_q     <= disp_d;
    end
  end

  assign stim_led = stim_q;
  assign disp_sel = disp_q;
  assign react_ms = react_q;
  assign state    = state_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with a short ms period so whole games fit in a
// few hundred cycles; expected wait lengths come from an independent LFSR model.
module tb_reaction_ctrl;

  localparam int CPM  = 4;
  localparam int WMIN = 3;
  localparam int RB   = 2;
  localparam int TMO  = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_btn = 1'b0;
  logic        stop_btn = 1'b0;
  logic        clear_btn = 1'b0;
  logic        timer_clr, timer_inc, stim_led;
  logic [1:0]  disp_sel;
  logic [13:0] react_ms;
  logic [2:0]  state;

  int          n_checks = 0;
  int          n_fail = 0;
  int          inc_cnt = 0;
  int          clr_cnt = 0;
  int          bad_pulse = 0;
  logic [15:0] tb_lfsr;

  reaction_ctrl #(
    .CLK_PER_MS (CPM),
    .WAIT_MIN_MS(WMIN),
    .RAND_BITS  (RB),
    .TIMEOUT_MS (TMO)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .start_btn (start_btn),
    .stop_btn  (stop_btn),
    .clear_btn (clear_btn),
    .timer_clr (timer_clr),
    .timer_inc (timer_inc),
    .stim_led  (stim_led),
    .disp_sel  (disp_sel),
    .react_ms  (react_ms),
    .state     (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_lfsr <= 16'hACE1;
    else        tb_lfsr <= {tb_lfsr[14:0], tb_lfsr[15] ^ tb_lfsr[13] ^ tb_lfsr[12] ^ tb_lfsr[10]};
  end

  always @(negedge clk) begin
    if (timer_inc === 1'b1) inc_cnt++;
    if (timer_clr === 1'b1) clr_cnt++;
    if (timer_inc === 1'b1 && state !== 3'd2) bad_pulse++;
    if (timer_clr === 1'b1 && state !== 3'd0) bad_pulse++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       start_btn = v;
      1:       stop_btn  = v;
      default: clear_btn = v;
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the edge has been acted on.
  task automatic press(input int which);
    set_btn(which, 1'b1);
    repeat (3) @(negedge clk);
    set_btn(which, 1'b0);
  endtask

  task automatic do_start(output int tgt);
    int clr0;
    clr0 = clr_cnt;
    start_btn = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (timer_clr !== 1'b1) begin n_fail++; $display("FAIL clr_pulse: got %0d, expected 1", timer_clr); end
    tgt = (WMIN + int'(tb_lfsr[RB-1:0])) * CPM;
    @(negedge clk);
    start_btn = 1'b0;
    n_checks++;
    if (state !== 3'd1) begin n_fail++; $display("FAIL wait_state: got %0d, expected 1", state); end
    n_checks++;
    if (disp_sel !== 2'd1) begin n_fail++; $display("FAIL wait_disp: got %0d, expected 1", disp_sel); end
    n_checks++;
    if (clr_cnt - clr0 != 1) begin n_fail++; $display("FAIL clr_once: got %0d, expected 1", clr_cnt - clr0); end
  endtask

  task automatic wait_react(input int tgt);
    int  i;
    bit  hit;
    hit = 1'b0;
    for (i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (state === 3'd2) begin hit = 1'b1; break; end
    end
    n_checks++;
    if (!hit || i != tgt) begin n_fail++; $display("FAIL wait_len: got %0d, expected %0d", i, tgt); end
    n_checks++;
    if (stim_led !== 1'b1) begin n_fail++; $display("FAIL react_led: got %0d, expected 1", stim_led); end
    n_checks++;
    if (disp_sel !== 2'd2) begin n_fail++; $display("FAIL react_disp: got %0d, expected 2", disp_sel); end
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d, expected 0", state); end
    n_checks++;
    if ({timer_clr, timer_inc, stim_led, disp_sel} !== 5'd0) begin
      n_fail++; $display("FAIL rst_outs: got %0d, expected 0", {timer_clr, timer_inc, stim_led, disp_sel});
    end
    n_checks++;
    if (react_ms !== 14'd0) begin n_fail++; $display("FAIL rst_react: got %0d, expected 0", react_ms); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (state !== 3'd0 || clr_cnt != 0) begin
      n_fail++; $display("FAIL idle_after_rst: got state %0d clr %0d, expected 0 0", state, clr_cnt);
    end
  endtask

  task automatic test_normal;
    int tgt, inc0, clr0;
    do_start(tgt);
    wait_react(tgt);
    inc0 = inc_cnt;
    repeat (19) @(negedge clk);
    press(1);
    n_checks++;
    if (state !== 3'd3) begin n_fail++; $display("FAIL result_state: got %0d, expected 3", state); end
    n_checks++;
    if (react_ms !== 14'd5) begin n_fail++; $display("FAIL result_ms: got %0d, expected 5", react_ms); end
    n_checks++;
    if (inc_cnt - inc0 != 5) begin n_fail++; $display("FAIL result_incs: got %0d, expected 5", inc_cnt - inc0); end
    n_checks++;
    if (stim_led !== 1'b0 || disp_sel !== 2'd2) begin
      n_fail++; $display("FAIL result_outs: got led %0d disp %0d, expected 0 2", stim_led, disp_sel);
    end
    clr0 = clr_cnt;
    press(0);
    repeat (4) @(negedge clk);
    n_checks++;
    if (state !== 3'd3 || react_ms !== 14'd5 || clr_cnt != clr0) begin
      n_fail++; $display("FAIL start_in_result: got state %0d ms %0d, expected 3 5", state, react_ms);
    end
    press(2);
    n_checks++;
    if (state !== 3'd0 || disp_sel !== 2'd0) begin
      n_fail++; $display("FAIL clear_result: got state %0d disp %0d, expected 0 0", state, disp_sel);
    end
    press(1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL stop_in_idle: got %0d, expected 0", state); end
  endtask

  task automatic test_cheat;
    int tgt, inc0;
    inc0 = inc_cnt;
    do_start(tgt);
    press(1);
    n_checks++;
    if (state !== 3'd5 || disp_sel !== 2'd3) begin
      n_fail++; $display("FAIL cheat: got state %0d disp %0d, expected 5 3", state, disp_sel);
    end
    repeat (3 * tgt) @(negedge clk);
    n_checks++;
    if (state !== 3'd5 || inc_cnt != inc0) begin
      n_fail++; $display("FAIL cheat_hold: got state %0d incs %0d, expected 5 0", state, inc_cnt - inc0);
    end
    press(2);
    n_checks++;
    if (state !== 3'd0 || disp_sel !== 2'd0) begin
      n_fail++; $display("FAIL cheat_clear: got state %0d disp %0d, expected 0 0", state, disp_sel);
    end
  endtask

  task automatic test_timeout;
    int tgt, inc0;
    do_start(tgt);
    wait_react(tgt);
    inc0 = inc_cnt;
    repeat (39) @(negedge clk);
    n_checks++;
    if (state !== 3'd2 || react_ms !== 14'd9) begin
      n_fail++; $display("FAIL pre_timeout: got state %0d ms %0d, expected 2 9", state, react_ms);
    end
    @(negedge clk);
    n_checks++;
    if (state !== 3'd4 || react_ms !== 14'd10) begin
      n_fail++; $display("FAIL timeout: got state %0d ms %0d, expected 4 10", state, react_ms);
    end
    n_checks++;
    if (inc_cnt - inc0 != 10) begin n_fail++; $display("FAIL timeout_incs: got %0d, expected 10", inc_cnt - inc0); end
    repeat (12) @(negedge clk);
    n_checks++;
    if (state !== 3'd4 || inc_cnt - inc0 != 10 || stim_led !== 1'b0) begin
      n_fail++; $display("FAIL timeout_hold: got state %0d incs %0d, expected 4 10", state, inc_cnt - inc0);
    end
    press(2);
  endtask

  task automatic test_simultaneous;
    int tgt, inc0;
    do_start(tgt);
    wait_react(tgt);
    inc0 = inc_cnt;
    repeat (37) @(negedge clk);
    press(1);
    n_checks++;
    if (state !== 3'd3 || react_ms !== 14'd10) begin
      n_fail++; $display("FAIL stop_on_timeout: got state %0d ms %0d, expected 3 10", state, react_ms);
    end
    n_checks++;
    if (inc_cnt - inc0 != 10) begin n_fail++; $display("FAIL stop_on_timeout_incs: got %0d, expected 10", inc_cnt - inc0); end
    press(2);
    inc0 = inc_cnt;
    do_start(tgt);
    repeat (tgt - 3) @(negedge clk);
    press(1);
    n_checks++;
    if (state !== 3'd5 || inc_cnt != inc0) begin
      n_fail++; $display("FAIL stop_on_target: got state %0d incs %0d, expected 5 0", state, inc_cnt - inc0);
    end
    press(2);
  endtask

  task automatic test_abort;
    int tgt, inc0, clr0;
    do_start(tgt);
    wait_react(tgt);
    inc0 = inc_cnt;
    @(negedge clk);
    press(2);
    n_checks++;
    if (state !== 3'd0 || stim_led !== 1'b0) begin
      n_fail++; $display("FAIL clear_react: got state %0d led %0d, expected 0 0", state, stim_led);
    end
    n_checks++;
    if (inc_cnt != inc0 || react_ms !== 14'd0) begin
      n_fail++; $display("FAIL clear_react_inc: got incs %0d ms %0d, expected 0 0", inc_cnt - inc0, react_ms);
    end
    do_start(tgt);
    wait_react(tgt);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0 || react_ms !== 14'd0) begin
      n_fail++; $display("FAIL async_rst: got state %0d ms %0d, expected 0 0", state, react_ms);
    end
    n_checks++;
    if ({timer_clr, timer_inc, stim_led, disp_sel} !== 5'd0) begin
      n_fail++; $display("FAIL async_rst_outs: got %0d, expected 0", {timer_clr, timer_inc, stim_led, disp_sel});
    end
    @(negedge clk);
    rst_n = 1'b1;
    inc0 = inc_cnt;
    clr0 = clr_cnt;
    repeat (10) @(negedge clk);
    n_checks++;
    if (state !== 3'd0 || inc_cnt != inc0 || clr_cnt != clr0) begin
      n_fail++; $display("FAIL post_rst_quiet: got state %0d incs %0d clrs %0d, expected 0 0 0",
                         state, inc_cnt - inc0, clr_cnt - clr0);
    end
  endtask

  task automatic test_held;
    int clr0;
    rst_n = 1'b0;
    start_btn = 1'b1;
    repeat (2) @(negedge clk);
    clr0 = clr_cnt;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (state !== 3'd1) begin n_fail++; $display("FAIL held_start: got %0d, expected 1", state); end
    repeat (5) @(negedge clk);
    n_checks++;
    if (state !== 3'd1 || clr_cnt - clr0 != 1) begin
      n_fail++; $display("FAIL held_once: got state %0d clrs %0d, expected 1 1", state, clr_cnt - clr0);
    end
    press(2);
    repeat (6) @(negedge clk);
    n_checks++;
    if (state !== 3'd0 || clr_cnt - clr0 != 1) begin
      n_fail++; $display("FAIL held_no_restart: got state %0d clrs %0d, expected 0 1", state, clr_cnt - clr0);
    end
    start_btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_cheat();
    test_timeout();
    test_simultaneous();
    test_abort();
    test_held();
    n_checks++;
    if (bad_pulse != 0) begin n_fail++; $display("FAIL stray_pulses: got %0d, expected 0", bad_pulse); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_ctrl.md
REACTION_CTRL -- requirements
Module: reaction_ctrl

Interface
REQ-001 SHALL have parameter CLK_PER_MS, default 100000, meaning clock cycles per 1 ms tick.
REQ-002 SHALL have parameter WAIT_MIN_MS, default 2000, meaning minimum random wait before the stimulus, in ms.
REQ-003 SHALL have parameter RAND_BITS, default 11, meaning width of the random wait offset (0..2^RAND_BITS-1 ms).
REQ-004 SHALL have parameter TIMEOUT_MS, default 1000, meaning the reaction window in ms.
REQ-005 SHALL have port CLK100MHZ, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port CPU_RESETN, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start_btn, input, 1 bit: asynchronous start button.
REQ-008 SHALL have port stop_btn, input, 1 bit: asynchronous reaction button.
REQ-009 SHALL have port clear_btn, input, 1 bit: asynchronous abort/return button.
REQ-010 SHALL have port timer_clr, output, 1 bit: one-cycle clear pulse to the external BCD ms counter chain.
REQ-011 SHALL have port timer_inc, output, 1 bit: one-cycle increment pulse per elapsed ms, sent to the BCD chain.
REQ-012 SHALL have port stim_led, output, 1 bit: stimulus light.
REQ-013 SHALL have port disp_sel, output, 2 bits: 0 = intro "HI", 1 = blank, 2 = timer digits, 3 = cheat pattern.
REQ-014 SHALL have port react_ms, output, 14 bits: binary reaction time in ms.
REQ-015 SHALL have port state, output, 3 bits: current FSM state.

Function
REQ-016 SHALL pass each button through a two-flop synchronizer.
REQ-017 SHALL act on the rising edge of each button only: edge = sync2 & ~sync3, so the state changes on the 3rd clock edge after the pin rises.
REQ-018 SHALL use state encoding IDLE=0, WAIT=1, REACT=2, RESULT=3, TIMEOUT=4, CHEAT=5; codes 6-7 SHALL return to IDLE on the next clock.
REQ-019 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) that advances every clock in every state.
REQ-020 IDLE: disp_sel=0, stim_led=0; a start edge SHALL go to WAIT, latch wait_target = WAIT_MIN_MS + lfsr[RAND_BITS-1:0], pulse timer_clr for exactly 1 cycle, and clear react_ms, the ms prescaler and the ms counter.
REQ-021 The ms prescaler SHALL count 0..CLK_PER_MS-1 only in WAIT and REACT, raising ms_tick on terminal count; it SHALL be cleared on entry to WAIT and to REACT, so the first tick occurs CLK_PER_MS cycles after entry.
REQ-022 WAIT: disp_sel=1, stim_led=0; the ms counter SHALL increment per ms_tick.
REQ-023 WAIT: a stop edge SHALL go to CHEAT.
REQ-024 WAIT: otherwise, the ms_tick that brings the counter to wait_target SHALL go to REACT and clear the ms counter.
REQ-025 WAIT: a stop edge in the same cycle as the target tick SHALL go to CHEAT.
REQ-026 REACT: stim_led=1, disp_sel=2; each ms_tick SHALL produce timer_inc in the same cycle and increment react_ms.
REQ-027 REACT: a stop edge SHALL go to RESULT with react_ms frozen.
REQ-028 REACT: the tick that makes react_ms == TIMEOUT_MS SHALL go to TIMEOUT.
REQ-029 REACT: a stop edge coinciding with the timeout tick SHALL go to RESULT and SHALL count that tick.
REQ-030 RESULT and TIMEOUT SHALL drive disp_sel=2, stim_led=0 and hold react_ms; CHEAT SHALL drive disp_sel=3, stim_led=0.
REQ-031 In RESULT, TIMEOUT and CHEAT, a clear edge SHALL go to IDLE, and start and stop edges SHALL be ignored.
REQ-032 In WAIT and REACT, a clear edge SHALL go to IDLE with priority over every other event, with no timer_inc pulse in that cycle.
REQ-033 Start edges SHALL be ignored outside IDLE; stop edges SHALL be ignored in IDLE.
REQ-034 react_ms SHALL saturate at 16383 and never wrap.
REQ-035 timer_inc SHALL never be asserted outside REACT, and timer_clr SHALL never be asserted except on the IDLE-to-WAIT transition.

Reset
REQ-036 CPU_RESETN low SHALL immediately force state=IDLE, timer_clr=0, timer_inc=0, stim_led=0, disp_sel=0, react_ms=0, the prescaler and ms counter to 0, the LFSR to 16'hACE1 and the sync flops to 0, independent of the clock.
REQ-037 Reset asserted mid-operation SHALL abandon the operation with no further pulses.
REQ-038 A button held high through reset release SHALL register as one edge.

Verification (CLK_PER_MS=4, WAIT_MIN_MS=3, RAND_BITS=2, TIMEOUT_MS=10)
REQ-039 Normal run: reset, start -> timer_clr pulse, WAIT; after (3+offset)*4 cycles -> REACT, stim_led=1; stop after 5 ticks -> RESULT, react_ms=5, exactly 5 timer_inc pulses.
REQ-040 Cheat: stop pressed in WAIT -> CHEAT, disp_sel=3, no timer_inc ever; clear -> IDLE, disp_sel=0.
REQ-041 Timeout: no stop in REACT -> TIMEOUT after exactly 40 cycles, react_ms=10, 10 timer_inc pulses.
REQ-042 Simultaneous: stop edge on the 10th tick -> RESULT, react_ms=10; stop edge on the target tick in WAIT -> CHEAT.
REQ-043 Abort/reset: clear during REACT -> IDLE next edge with no timer_inc that cycle; CPU_RESETN low mid-REACT -> all outputs 0 and state=0 without a clock edge.
REQ-044 Ignored inputs: start in RESULT, stop in IDLE, and a held button -> no transition beyond a single edge.
